// File: rtl/ir_nec_encoder.sv
// rtl/ir_nec_encoder.sv - NEC infrared frame / repeat-code transmitter with 38 kHz carrier
//
// Purpose:
//   Serialises {tx_data, tx_addr} (LSB of tx_addr first) into one NEC frame,
//   or sends a NEC repeat code, then holds off new requests for T_GAP cycles.
//   Drives the IR LED with a gated carrier and an active-low envelope for
//   loopback into the on-chip receiver.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   tx_start   request a full frame (sampled only while tx_ready=1, wins over tx_repeat)
//   tx_repeat  request a repeat code (sampled only while tx_ready=1)
//   tx_addr    16-bit address, frame bits 0..15
//   tx_data    16-bit data, frame bits 16..31
//   tx_ready   idle and able to accept a request
//   tx_busy    frame, repeat code or gap in progress
//   tx_done    one-cycle pulse on the first gap cycle
//   ir_led     modulated LED drive, carrier only during marks
//   ir_env_n   envelope, 0 during marks, 1 otherwise
module ir_nec_encoder #(
  parameter int unsigned T_LEAD_MARK  = 450000,
  parameter int unsigned T_LEAD_SPACE = 225000,
  parameter int unsigned T_REP_SPACE  = 112500,
  parameter int unsigned T_BIT_MARK   = 28000,
  parameter int unsigned T_ZERO_SPACE = 28000,
  parameter int unsigned T_ONE_SPACE  = 84500,
  parameter int unsigned T_GAP        = 2000000,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic        tx_repeat,
  input  logic [15:0] tx_addr,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        ir_led,
  output logic        ir_env_n
);

  localparam int unsigned CNT_W = 22;
  localparam int unsigned CAR_W = $clog2(2 * CARRIER_HALF);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(2 * CARRIER_HALF - 1);
  localparam logic [CAR_W-1:0] CAR_HALF = CAR_W'(CARRIER_HALF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_REP_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [5:0]       bit_cnt, bit_next;
  logic [31:0]      sr, sr_next;
  logic             rep_q, rep_next;
  logic [CAR_W-1:0] car, car_next;
  logic             mark_next;

  // Counter reload value: a state lasting N cycles starts at N-1 and leaves at 0.
  function automatic logic [CNT_W-1:0] dur_of(input state_t s, input logic lsb);
    logic [CNT_W-1:0] d;
    d = '0;
    case (s)
      S_LEAD_MARK:  d = CNT_W'(T_LEAD_MARK - 1);
      S_LEAD_SPACE: d = CNT_W'(T_LEAD_SPACE - 1);
      S_REP_SPACE:  d = CNT_W'(T_REP_SPACE - 1);
      S_BIT_MARK:   d = CNT_W'(T_BIT_MARK - 1);
      S_BIT_SPACE:  d = lsb ? CNT_W'(T_ONE_SPACE - 1) : CNT_W'(T_ZERO_SPACE - 1);
      S_STOP_MARK:  d = CNT_W'(T_BIT_MARK - 1);
      S_GAP:        d = CNT_W'(T_GAP - 1);
      default:      d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    bit_next   = bit_cnt;
    sr_next    = sr;
    rep_next   = rep_q;
    car_next   = '0;

    case (state)
      S_IDLE: begin
        if (tx_start) begin
          state_next = S_LEAD_MARK;
          sr_next    = {tx_data, tx_addr};
          rep_next   = 1'b0;
        end else if (tx_repeat) begin
          state_next = S_LEAD_MARK;
          sr_next    = {tx_data, tx_addr};
          rep_next   = 1'b1;
        end
      end
      S_LEAD_MARK:  if (cnt == '0) state_next = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
      S_LEAD_SPACE: begin
        if (cnt == '0) begin
          state_next = S_BIT_MARK;
          bit_next   = '0;
        end
      end
      S_REP_SPACE:  if (cnt == '0) state_next = S_STOP_MARK;
      S_BIT_MARK:   if (cnt == '0) state_next = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (cnt == '0) begin
          sr_next = {1'b0, sr[31:1]};
          if (bit_cnt == 6'd31) begin
            state_next = S_STOP_MARK;
            bit_next   = '0;
          end else begin
            state_next = S_BIT_MARK;
            bit_next   = bit_cnt + 6'd1;
          end
        end
      end
      S_STOP_MARK:  if (cnt == '0) state_next = S_GAP;
      S_GAP:        if (cnt == '0) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase

    // Every transition reloads the counter; in BIT_MARK sr[0] is the bit whose space follows.
    if (state_next != state) cnt_next = dur_of(state_next, sr[0]);

    // Carrier restarts high on every mark entry so each mark begins with a full high half.
    mark_next = is_mark(state_next);
    if (mark_next && (state_next == state)) begin
      car_next = (car == CAR_LAST) ? '0 : car + CAR_W'(1);
    end
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rep_q    <= 1'b0;
      car      <= '0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      ir_led   <= 1'b0;
      ir_env_n <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_cnt  <= bit_next;
      sr       <= sr_next;
      rep_q    <= rep_next;
      car      <= car_next;
      tx_ready <= (state_next == S_IDLE);
      tx_busy  <= (state_next != S_IDLE);
      tx_done  <= (state == S_STOP_MARK) && (state_next == S_GAP);
      ir_led   <= mark_next && (car_next < CAR_HALF);
      ir_env_n <= ~mark_next;
    end
  end

endmodule

// File: tb/tb_ir_nec_encoder.sv
// tb/tb_ir_nec_encoder.sv - self-checking bench for ir_nec_encoder with scaled timing
module tb_ir_nec_encoder;

  localparam int LM  = 90;
  localparam int LS  = 45;
  localparam int RS  = 23;
  localparam int BM  = 6;
  localparam int ZS  = 6;
  localparam int OS  = 17;
  localparam int GAP = 40;
  localparam int CH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start, tx_repeat;
  logic [15:0] tx_addr, tx_data;
  logic        tx_ready, tx_busy, tx_done, ir_led, ir_env_n;

  always #5 clk = ~clk;

  ir_nec_encoder #(
    .T_LEAD_MARK(LM), .T_LEAD_SPACE(LS), .T_REP_SPACE(RS), .T_BIT_MARK(BM),
    .T_ZERO_SPACE(ZS), .T_ONE_SPACE(OS), .T_GAP(GAP), .CARRIER_HALF(CH)
  ) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_data(tx_data), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_done(tx_done), .ir_led(ir_led), .ir_env_n(ir_env_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, one entry per cycle after acceptance.
  typedef struct packed {
    logic env_n;
    logic led;
    logic done;
    logic busy;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_EXP = 5'b10001;

  exp_t        exp_q[$];
  bit          idle_cycle = 1'b0;
  bit          started    = 1'b0;
  logic [31:0] acc_word   = '0;
  bit          acc_rep    = 1'b0;

  task automatic add_seg(input bit mark, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.env_n = ~mark;
      e.led   = mark && ((k % (2 * CH)) < CH);
      e.done  = 1'b0;
      e.busy  = 1'b1;
      e.ready = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic build(input logic [31:0] w, input bit rep);
    exp_t e;
    add_seg(1'b1, LM);
    if (rep) begin
      add_seg(1'b0, RS);
    end else begin
      add_seg(1'b0, LS);
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, BM);
        add_seg(1'b0, w[i] ? OS : ZS);
      end
    end
    add_seg(1'b1, BM);
    for (int k = 0; k < GAP; k++) begin
      e.env_n = 1'b1;
      e.led   = 1'b0;
      e.done  = (k == 0);
      e.busy  = 1'b1;
      e.ready = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  function automatic int span_of(input logic [31:0] w, input bit rep);
    int s;
    if (rep) return LM + RS + BM;
    s = LM + LS + 33 * BM;
    for (int i = 0; i < 32; i++) s += w[i] ? OS : ZS;
    return s;
  endfunction

  // Reference model: accepts on a cycle whose expected outputs were idle.
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      exp_q.delete();
    end else if (started && idle_cycle && (tx_start || tx_repeat)) begin
      acc_word = {tx_data, tx_addr};
      acc_rep  = !tx_start;
      build(acc_word, acc_rep);
      if (acc_rep) check("model_len_repeat", exp_q.size(), 32'd159);
      else if (acc_word == 32'hE51A00FF) check("model_len_frame", exp_q.size(), 32'd741);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        idle_cycle = 1'b0;
      end else begin
        e = IDLE_EXP;
        idle_cycle = 1'b1;
      end
      check("outputs{env_n,led,done,busy,ready}",
            {27'd0, ir_env_n, ir_led, tx_done, tx_busy, tx_ready}, {27'd0, e});
    end
  end

  // Envelope decoder: measures mark/space runs and decodes them at tx_done.
  int   runs[$];
  int   cur_len = 0;
  logic prev_env = 1'b1;

  always @(negedge clk) begin
    int          span;
    logic [31:0] w;
    bit          ok;
    if (started) begin
      if (ir_env_n !== prev_env) begin
        if (prev_env == 1'b0 || runs.size() > 0) runs.push_back(cur_len);
        cur_len = 1;
      end else begin
        cur_len++;
      end
      prev_env = ir_env_n;
      if (tx_ready) runs.delete();
      if (tx_done === 1'b1) begin
        span = 0;
        foreach (runs[i]) span += runs[i];
        check("decode_span", span, span_of(acc_word, acc_rep));
        if (runs.size() == 67 && runs[1] == LS) begin
          ok = 1'b1;
          w  = '0;
          for (int i = 0; i < 32; i++) begin
            if (runs[2 + 2 * i] != BM) ok = 1'b0;
            if (runs[3 + 2 * i] == OS) w[i] = 1'b1;
            else if (runs[3 + 2 * i] != ZS) ok = 1'b0;
          end
          check("decode_is_frame", 32'(acc_rep), 32'd0);
          check("decode_timing_ok", 32'(ok), 32'd1);
          check("decode_word", w, acc_word);
          if (acc_word == 32'hE51A00FF && !acc_rep) begin
            check("pin_span_00FF_E51A", span, 32'd701);
            check("pin_lead_mark", runs[0], 32'd90);
            check("pin_lead_space", runs[1], 32'd45);
            check("pin_bit0_mark", runs[2], 32'd6);
            check("pin_bit0_space", runs[3], 32'd17);
          end
        end else if (runs.size() == 3 && runs[1] == RS) begin
          check("decode_is_repeat", 32'(acc_rep), 32'd1);
          check("pin_repeat_runs", {runs[0][7:0], runs[1][7:0], runs[2][7:0]}, {8'd90, 8'd23, 8'd6});
        end else begin
          check("decode_shape_runs", runs.size(), acc_rep ? 32'd3 : 32'd67);
        end
        runs.delete();
      end
    end
  end

  task automatic wait_ready(input int budget);
    int k = 0;
    while (tx_ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready timeout got=%b expected=1", tx_ready);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (tx_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx_done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done timeout got=%b expected=1", tx_done);
    end
  endtask

  task automatic send(input bit s, input bit r, input logic [15:0] a, input logic [15:0] d);
    wait_ready(3000);
    tx_addr = a; tx_data = d; tx_start = s; tx_repeat = r;
    @(negedge clk);
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  task automatic pulse_junk();
    tx_addr = 16'($urandom); tx_data = 16'($urandom); tx_start = 1'b1; tx_repeat = 1'($urandom);
    @(negedge clk);
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, hold;
    rst = 1'b1; tx_start = 1'b0; tx_repeat = 1'b0; tx_addr = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, ir_env_n, ir_led, tx_done, tx_busy, tx_ready}, 32'b10001);
    rst = 1'b0;
    @(negedge clk);

    // Directed frame: 16 ones and 16 zeros.
    send(1'b1, 1'b0, 16'h00FF, 16'hE51A);
    @(negedge clk);
    check("ready_drops_after_accept", 32'(tx_ready), 32'd0);
    wait_ready(3000);

    // Repeat code.
    send(1'b0, 1'b1, 16'h1234, 16'h5678);
    wait_ready(3000);

    // Both requests together: frame wins.
    send(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    wait_ready(3000);

    // Requests during LEAD_SPACE and GAP are ignored.
    send(1'b1, 1'b0, 16'hA55A, 16'h0F0F);
    repeat (LM + 5) @(negedge clk);
    pulse_junk();
    wait_done(3000);
    repeat (5) @(negedge clk);
    pulse_junk();
    wait_ready(3000);

    // Randomized requests with held inputs and stray pulses.
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 2);
      hold = $urandom_range(1, 3);
      wait_ready(3000);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tx_addr = 16'($urandom); tx_data = 16'($urandom);
      tx_start = (kind != 1); tx_repeat = (kind != 0);
      repeat (hold) @(negedge clk);
      tx_start = 1'b0; tx_repeat = 1'b0;
      repeat ($urandom_range(1, 200)) @(negedge clk);
      pulse_junk();
    end

    // Reset mid-operation aborts without tx_done; then a clean frame.
    wait_ready(3000);
    send(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    repeat ($urandom_range(1, 700)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_midframe_reset", 32'(tx_ready), 32'd1);
    send(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    wait_ready(3000);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
